// File: rtl/motor_regbank_pkg.sv
// Shared definitions for the motor control register bank: register map,
// per-motor configuration/telemetry layouts and the read FSM state type.
package motor_regbank_pkg;

  // Per-motor register indices (address[7:0])
  localparam logic [7:0] REG_KP       = 8'h01;
  localparam logic [7:0] REG_KI       = 8'h02;
  localparam logic [7:0] REG_KD       = 8'h03;
  localparam logic [7:0] REG_POS      = 8'h04;
  localparam logic [7:0] REG_VEL      = 8'h05;
  localparam logic [7:0] REG_DISP     = 8'h06;
  localparam logic [7:0] REG_CUR      = 8'h07;
  localparam logic [7:0] REG_PWM_LIM  = 8'h08;
  localparam logic [7:0] REG_INT_LIM  = 8'h09;
  localparam logic [7:0] REG_DEADBAND = 8'h0A;
  localparam logic [7:0] REG_MODE     = 8'h0B;
  localparam logic [7:0] REG_SP       = 8'h0C;
  // Stale/age: bit 31 = stale flag, bits 30:0 = cycles since last capture
  localparam logic [7:0] REG_AGE      = 8'h0D;

  // Global registers, decoded for any motor index
  localparam logic [7:0] REG_COMMIT   = 8'h10;
  localparam logic [7:0] REG_NUM      = 8'h11;
  localparam logic [7:0] REG_WDT      = 8'h12;

  // Returned for unmapped registers and absent motors
  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // Cycles without a nonzero COMMIT before the watchdog trips
  localparam int WDT_CYCLES = 5_000_000;

  // Active/shadow configuration of one motor, sp in the MSBs
  typedef struct packed {
    logic [31:0] sp;
    logic [31:0] kp;
    logic [31:0] ki;
    logic [31:0] kd;
    logic [31:0] pwm_lim;
    logic [31:0] int_lim;
    logic [31:0] deadband;
    logic [7:0]  mode;
  } motor_cfg_t;

  // Telemetry of one motor as delivered by the comms engine
  typedef struct packed {
    logic [31:0] pos;
    logic [31:0] vel;
    logic [31:0] disp;
    logic [15:0] cur;
  } motor_stat_t;

  localparam int CFG_W  = $bits(motor_cfg_t);
  localparam int STAT_W = $bits(motor_stat_t);

  // Bus read FSM: one wait state per read
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // Power-on configuration: gains seeded from the motor index
  function automatic motor_cfg_t cfg_reset_value(input int unsigned idx);
    motor_cfg_t v;
    v    = '0;
    v.kp = 32'h0000_000A + idx;
    v.ki = 32'h0000_000B + idx;
    v.kd = 32'h0000_000C + idx;
    return v;
  endfunction

endpackage

// File: rtl/motor_regbank_chan.sv
// One motor's slice of the register bank: shadow and active configuration,
// captured telemetry, and the telemetry freshness counter.
module motor_regbank_chan
  import motor_regbank_pkg::*;
#(
  parameter int MOTOR_IDX    = 0,
  parameter int STALE_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_reg_i,
  input  logic [31:0] wr_data_i,
  input  logic        commit_i,
  input  logic        wdt_trip_i,
  input  motor_stat_t stat_i,
  input  logic        stat_valid_i,
  output motor_cfg_t  shadow_o,
  output motor_cfg_t  active_o,
  output motor_stat_t stat_o,
  output logic [30:0] age_o,
  output logic        stale_o,
  output logic        cfg_update_o
);

  localparam int AGE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_CYCLES);

  motor_cfg_t       shadow_q, shadow_d;
  motor_cfg_t       active_q, active_d;
  motor_stat_t      stat_q, stat_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             update_q, update_d;

  // Bus writes land in the shadow copy only
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) begin
      case (wr_reg_i)
        REG_KP:       shadow_d.kp       = wr_data_i;
        REG_KI:       shadow_d.ki       = wr_data_i;
        REG_KD:       shadow_d.kd       = wr_data_i;
        REG_PWM_LIM:  shadow_d.pwm_lim  = wr_data_i;
        REG_INT_LIM:  shadow_d.int_lim  = wr_data_i;
        REG_DEADBAND: shadow_d.deadband = wr_data_i;
        REG_MODE:     shadow_d.mode     = wr_data_i[7:0];
        REG_SP:       shadow_d.sp       = wr_data_i;
        default:      ;
      endcase
    end
  end

  // Commit copies the whole shadow at once; a watchdog trip parks the motor
  always_comb begin
    active_d = active_q;
    update_d = commit_i | wdt_trip_i;
    if (commit_i) begin
      active_d = shadow_q;
    end
    if (wdt_trip_i) begin
      active_d.mode = '0;
      active_d.sp   = '0;
    end
  end

  // Telemetry capture and saturating age counter
  always_comb begin
    stat_d = stat_q;
    age_d  = age_q;
    if (stat_valid_i) begin
      stat_d = stat_i;
      age_d  = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= cfg_reset_value(MOTOR_IDX);
      active_q <= cfg_reset_value(MOTOR_IDX);
      stat_q   <= '0;
      age_q    <= AGE_MAX;
      update_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      stat_q   <= stat_d;
      age_q    <= age_d;
      update_q <= update_d;
    end
  end

  assign shadow_o     = shadow_q;
  assign active_o     = active_q;
  assign stat_o       = stat_q;
  assign age_o        = 31'(age_q);
  assign stale_o      = (age_q == AGE_MAX);
  assign cfg_update_o = update_q;

endmodule

// File: rtl/motor_ctrl_regbank.sv
// Avalon-MM register bank for NUM_MOTORS motor channels: address decode,
// read mux, one-wait-state read FSM and optional commit watchdog.
// Build option: define WATCHDOG_EN to add the commit watchdog and reg 0x12.
//
// Handshake: a write is accepted on every cycle it is asserted and is never
// stalled. A read asserted in RD_IDLE sees waitrequest=1 while readdata is
// registered; the following cycle (RD_WAIT) has waitrequest=0 and valid data.
// Dropping read during RD_WAIT abandons the access. waitrequest is held high
// while reset is asserted.
module motor_ctrl_regbank
  import motor_regbank_pkg::*;
#(
  parameter int NUM_MOTORS   = 6,
  parameter int DATA_W       = 32,
  parameter int STALE_CYCLES = 500000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  address,
  input  logic                         write,
  input  logic [DATA_W-1:0]            writedata,
  input  logic                         read,
  output logic [DATA_W-1:0]            readdata,
  output logic                         waitrequest,
  input  logic [NUM_MOTORS*STAT_W-1:0] stat_i,
  input  logic [NUM_MOTORS-1:0]        stat_valid_i,
  output logic [NUM_MOTORS*CFG_W-1:0]  cfg_o,
  output logic [NUM_MOTORS-1:0]        cfg_update_o,
  output logic [NUM_MOTORS-1:0]        stale_o
);

  logic [7:0]            motor_idx;
  logic [7:0]            reg_idx;
  logic [31:0]           wdata;
  logic [NUM_MOTORS-1:0] commit_mask;
  logic                  wdt_trip;

  motor_cfg_t  shadow_a [NUM_MOTORS];
  motor_cfg_t  active_a [NUM_MOTORS];
  motor_stat_t stat_a   [NUM_MOTORS];
  logic [30:0] age_a    [NUM_MOTORS];

  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] readdata_q;
  logic [31:0] rd_value;
  logic        rd_capture;

  assign motor_idx = address[15:8];
  assign reg_idx   = address[7:0];
  assign wdata     = 32'(writedata);

  // COMMIT is global: its mask selects motors regardless of the motor index
  assign commit_mask = (write && (reg_idx == REG_COMMIT)) ? NUM_MOTORS'(wdata) : '0;

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_chan
    motor_regbank_chan #(
      .MOTOR_IDX    (g),
      .STALE_CYCLES (STALE_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .wr_en_i      (write && (motor_idx == 8'(g))),
      .wr_reg_i     (reg_idx),
      .wr_data_i    (wdata),
      .commit_i     (commit_mask[g]),
      .wdt_trip_i   (wdt_trip),
      .stat_i       (stat_i[g*STAT_W +: STAT_W]),
      .stat_valid_i (stat_valid_i[g]),
      .shadow_o     (shadow_a[g]),
      .active_o     (active_a[g]),
      .stat_o       (stat_a[g]),
      .age_o        (age_a[g]),
      .stale_o      (stale_o[g]),
      .cfg_update_o (cfg_update_o[g])
    );
    assign cfg_o[g*CFG_W +: CFG_W] = active_a[g];
  end

`ifdef WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic             commit_nz;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_fault_q, wdt_fault_d;

  assign commit_nz = |commit_mask;

  // Count cycles since the last nonzero COMMIT; trip exactly once on reaching the limit
  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    wdt_trip    = 1'b0;
    if (commit_nz) begin
      wdt_cnt_d   = '0;
      wdt_fault_d = 1'b0;
    end else if (wdt_cnt_q != WDT_W'(WDT_CYCLES)) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
      if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
        wdt_trip    = 1'b1;
        wdt_fault_d = 1'b1;
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdt_cnt_q   <= '0;
      wdt_fault_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fault_q <= wdt_fault_d;
    end
  end
`else
  assign wdt_trip = 1'b0;
`endif

  // Read mux: shadow config, captured telemetry, age; narrow fields sign-extend
  always_comb begin
    rd_value = DEADBEEF;
    if (reg_idx == REG_NUM) begin
      rd_value = 32'(NUM_MOTORS);
    end
`ifdef WATCHDOG_EN
    else if (reg_idx == REG_WDT) begin
      rd_value = {31'b0, wdt_fault_q};
    end
`endif
    else begin
      for (int m = 0; m < NUM_MOTORS; m++) begin
        if (motor_idx == 8'(m)) begin
          case (reg_idx)
            REG_KP:       rd_value = shadow_a[m].kp;
            REG_KI:       rd_value = shadow_a[m].ki;
            REG_KD:       rd_value = shadow_a[m].kd;
            REG_POS:      rd_value = stat_a[m].pos;
            REG_VEL:      rd_value = stat_a[m].vel;
            REG_DISP:     rd_value = stat_a[m].disp;
            REG_CUR:      rd_value = {{16{stat_a[m].cur[15]}}, stat_a[m].cur};
            REG_PWM_LIM:  rd_value = shadow_a[m].pwm_lim;
            REG_INT_LIM:  rd_value = shadow_a[m].int_lim;
            REG_DEADBAND: rd_value = shadow_a[m].deadband;
            REG_MODE:     rd_value = {{24{shadow_a[m].mode[7]}}, shadow_a[m].mode};
            REG_SP:       rd_value = shadow_a[m].sp;
            REG_AGE:      rd_value = {stale_o[m], age_a[m]};
            default:      rd_value = DEADBEEF;
          endcase
        end
      end
    end
  end

  // Read FSM next state and waitrequest
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_capture  = 1'b0;
    waitrequest = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (read) begin
          waitrequest = 1'b1;
          rd_capture  = 1'b1;
          rd_state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (reset) begin
      waitrequest = 1'b1;
    end
  end

  // Read FSM state and registered read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      readdata_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_capture) begin
        readdata_q <= rd_value;
      end
    end
  end

  assign readdata = DATA_W'(readdata_q);

endmodule

// File: tb/tb_motor_ctrl_regbank.sv
// Directed bench for motor_ctrl_regbank with a register-map level model.
module tb_motor_ctrl_regbank;

  localparam int NM    = 6;
  localparam int STALE = 20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0]       address = '0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic [NM*112-1:0] stat_i = '0;
  logic [NM-1:0]     stat_valid_i = '0;
  logic [NM*232-1:0] cfg_o;
  logic [NM-1:0]     cfg_update_o;
  logic [NM-1:0]     stale_o;

  motor_ctrl_regbank #(
    .NUM_MOTORS   (NM),
    .DATA_W       (32),
    .STALE_CYCLES (STALE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write        (write),
    .writedata    (writedata),
    .read         (read),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .stat_i       (stat_i),
    .stat_valid_i (stat_valid_i),
    .cfg_o        (cfg_o),
    .cfg_update_o (cfg_update_o),
    .stale_o      (stale_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- register-map model ----------------
  logic [31:0]  sh  [NM][16];
  logic [31:0]  act [NM][16];
  logic [111:0] tel [NM];
  longint       last_valid [NM];
  longint       step;
  logic [NM-1:0] upd_exp;
  bit           in_wait;
  logic [31:0]  exp_q [$];

  function automatic longint age_of(input int m);
    longint d;
    d = step - last_valid[m];
    return (d > STALE) ? longint'(STALE) : d;
  endfunction

  function automatic logic [231:0] exp_cfg(input int m);
    return {act[m][12], act[m][1], act[m][2], act[m][3],
            act[m][8], act[m][9], act[m][10], act[m][11][7:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    int unsigned mi;
    int unsigned ri;
    longint ag;
    mi = a[15:8];
    ri = a[7:0];
    if (ri == 'h11) return 32'd6;
`ifdef WATCHDOG_EN
    if (ri == 'h12) return 32'd0;
`endif
    if (mi >= NM) return 32'hDEADBEEF;
    case (ri)
      1, 2, 3, 8, 9, 10, 12: return sh[mi][ri];
      11: return {{24{sh[mi][11][7]}}, sh[mi][11][7:0]};
      4:  return tel[mi][111:80];
      5:  return tel[mi][79:48];
      6:  return tel[mi][47:16];
      7:  return {{16{tel[mi][15]}}, tel[mi][15:0]};
      13: begin
        ag = age_of(mi);
        return {(ag == STALE), 31'(ag)};
      end
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin
      for (int r = 0; r < 16; r++) sh[m][r] = '0;
      sh[m][1] = 32'(10 + m);
      sh[m][2] = 32'(11 + m);
      sh[m][3] = 32'(12 + m);
      for (int r = 0; r < 16; r++) act[m][r] = sh[m][r];
      tel[m] = '0;
      last_valid[m] = -longint'(STALE);
    end
    step    = 0;
    upd_exp = '0;
    in_wait = 1'b0;
    exp_q.delete();
  endtask

  // Apply what the bus and comms present this cycle as of the next edge
  task automatic model_step();
    logic [NM-1:0] cmask;
    int unsigned mi;
    int unsigned ri;
    cmask = '0;
    if (!in_wait && read) begin
      exp_q.push_back(model_read(address));
      in_wait = 1'b1;
    end else begin
      in_wait = 1'b0;
    end
    if (write) begin
      mi = address[15:8];
      ri = address[7:0];
      if (ri == 'h10) cmask = writedata[NM-1:0];
      else if (mi < NM) begin
        case (ri)
          1, 2, 3, 8, 9, 10, 12: sh[mi][ri] = writedata;
          11: sh[mi][11] = {24'b0, writedata[7:0]};
          default: ;
        endcase
      end
    end
    for (int m = 0; m < NM; m++)
      if (cmask[m]) for (int r = 0; r < 16; r++) act[m][r] = sh[m][r];
    upd_exp = cmask;
    step++;
    for (int m = 0; m < NM; m++) begin
      if (stat_valid_i[m]) begin
        tel[m] = stat_i[m*112 +: 112];
        last_valid[m] = step;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [NM-1:0] exp_stale;
    for (int m = 0; m < NM; m++) begin
      check($sformatf("cfg_o_m%0d", m), 256'(cfg_o[m*232 +: 232]), 256'(exp_cfg(m)));
      exp_stale[m] = (age_of(m) == STALE);
    end
    check("stale_o", 256'(stale_o), 256'(exp_stale));
    check("cfg_update_o", 256'(cfg_update_o), 256'(upd_exp));
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clock) begin
    logic [31:0] e;
    if (reset) begin
      model_reset();
      check("rst_waitrequest", 256'(waitrequest), 256'(1'b1));
      check("rst_readdata", 256'(readdata), 256'(0));
      compare_outputs();
    end else begin
      check("waitrequest", 256'(waitrequest), 256'(!in_wait && read));
      if (in_wait) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exp_q: read data phase with no expected value queued");
        end else begin
          e = exp_q.pop_front();
          if (read) check("readdata", 256'(readdata), 256'(e));
        end
      end
      compare_outputs();
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    int waits;
    waits   = 0;
    address = a;
    read    = 1'b1;
    #1;
    while (waitrequest && waits < 8) begin
      @(posedge clock);
      #1;
      waits++;
    end
    check("read_wait_states", 256'(waits), 256'(1));
    d = readdata;
    tick();
    read = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d;

    tick();
    check("lit_rst_wait", 256'(waitrequest), 256'(1));
    check("lit_rst_rdata", 256'(readdata), 256'(0));
    check("lit_rst_stale", 256'(stale_o), 256'(6'h3F));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset contents
    bus_read(16'h0201, d);
    check("lit_m2_kp_read", 256'(d), 256'(32'h0C));
    check("lit_m2_kp_cfg", 256'(cfg_o[632 +: 32]), 256'(32'h0C));
    bus_read(16'h0011, d);
    check("lit_num_motors", 256'(d), 256'(6));

    // shadow write, read back, commit
    bus_write(16'h010C, 32'h1234);
    bus_read(16'h010C, d);
    check("lit_m1_sp_shadow", 256'(d), 256'(32'h1234));
    check("lit_m1_sp_active_pre", 256'(cfg_o[432 +: 32]), 256'(0));
    bus_write(16'h0010, 32'h02);
    check("lit_m1_sp_active", 256'(cfg_o[432 +: 32]), 256'(32'h1234));
    check("lit_update_pulse", 256'(cfg_update_o), 256'(6'h02));
    tick();
    check("lit_update_end", 256'(cfg_update_o), 256'(0));

    // unmapped addresses
    bus_read(16'h0601, d);
    check("lit_m6_deadbeef", 256'(d), 256'(32'hDEADBEEF));
    bus_read(16'h0020, d);
    check("lit_reg20_deadbeef", 256'(d), 256'(32'hDEADBEEF));
    bus_write(16'h0601, 32'h55);
    bus_read(16'h0501, d);
    check("lit_m5_kp_untouched", 256'(d), 256'(32'h0F));
    bus_read(16'h0012, d);
`ifdef WATCHDOG_EN
    check("lit_reg12", 256'(d), 256'(0));
`else
    check("lit_reg12", 256'(d), 256'(32'hDEADBEEF));
`endif

    // mode sign extension; commit mask 0 is a no-op, then commit all
    bus_write(16'h000B, 32'h185);
    bus_read(16'h000B, d);
    check("lit_mode_sext", 256'(d), 256'(32'hFFFFFF85));
    bus_write(16'h0408, 32'h99);
    bus_write(16'h0010, 32'h0);
    check("lit_commit0_noop", 256'(cfg_update_o), 256'(0));
    bus_write(16'h0010, 32'h3F);
    check("lit_m4_pwm_active", 256'(cfg_o[1000 +: 32]), 256'(32'h99));
    check("lit_update_all", 256'(cfg_update_o), 256'(6'h3F));
    tick();

    // telemetry capture and freshness
    stat_i[3*112 +: 112] = {32'h11111111, 32'h22222222, 32'h33333333, 16'hFFF0};
    stat_valid_i = 6'b001000;
    tick();
    stat_valid_i = '0;
    check("lit_m3_fresh", 256'(stale_o[3]), 256'(0));
    bus_read(16'h0307, d);
    check("lit_m3_cur_sext", 256'(d), 256'(32'hFFFFFFF0));
    bus_read(16'h0305, d);
    check("lit_m3_vel", 256'(d), 256'(32'h22222222));
    repeat (STALE) tick();
    check("lit_m3_stale", 256'(stale_o[3]), 256'(1));
    bus_read(16'h030D, d);
    check("lit_m3_age", 256'(d), 256'(32'h80000014));

    // read and write together: read returns the pre-write value
    address   = 16'h0001;
    writedata = 32'h77;
    write     = 1'b1;
    read      = 1'b1;
    tick();
    write = 1'b0;
    check("lit_rw_wait", 256'(waitrequest), 256'(0));
    check("lit_rw_old", 256'(readdata), 256'(32'h0A));
    tick();
    read = 1'b0;
    bus_read(16'h0001, d);
    check("lit_rw_new", 256'(d), 256'(32'h77));

    // read abandoned during the wait state, then back-to-back reads
    address = 16'h0002;
    read    = 1'b1;
    tick();
    read = 1'b0;
    tick();
    address = 16'h0102;
    read    = 1'b1;
    tick();
    tick();
    address = 16'h0203;
    tick();
    tick();
    read = 1'b0;
    tick();

    // reset during the wait state of a read
    address = 16'h0101;
    read    = 1'b1;
    tick();
    reset = 1'b1;
    read  = 1'b0;
    #1;
    check("lit_midrd_wait", 256'(waitrequest), 256'(1));
    check("lit_midrd_rdata", 256'(readdata), 256'(0));
    check("lit_midrd_sp", 256'(cfg_o[432 +: 32]), 256'(0));
    check("lit_midrd_stale", 256'(stale_o), 256'(6'h3F));
    tick();
    tick();
    reset = 1'b0;
    tick();
    bus_read(16'h0101, d);
    check("lit_post_rst_kp", 256'(d), 256'(32'h0B));
    bus_read(16'h0304, d);
    check("lit_post_rst_tel", 256'(d), 256'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
